// File: rtl/c13_mult_pkg.sv
// c13_mult_pkg
//   Shared definitions for the 8x8 sequential multiplier built around the
//   4x4 array-multiplier core.
//   Contents:
//     state_t      FSM state encoding (IDLE, MUL, DONE)
//     CORE_W       operand width of the combinational core
//     OP_W/PROD_W  operand and product widths of the sequencer
//     step_shift   step index -> left shift applied to that step's partial product
//     pick_nibble  selects the low or high nibble of an operand
package c13_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CORE_W = 4;
  localparam int OP_W   = 2 * CORE_W;
  localparam int PROD_W = 2 * OP_W;
  localparam int STEP_W = 2;

  localparam logic [STEP_W-1:0] STEP_LAST = 2'd3;

  // Shift per step: lo*lo, hi*lo, lo*hi, hi*hi
  localparam logic [3:0] SHIFT_STEP0 = 4'd0;
  localparam logic [3:0] SHIFT_STEP1 = 4'd4;
  localparam logic [3:0] SHIFT_STEP2 = 4'd4;
  localparam logic [3:0] SHIFT_STEP3 = 4'd8;

  function automatic logic [3:0] step_shift(input logic [STEP_W-1:0] step);
    logic [3:0] sh;
    case (step)
      2'd0:    sh = SHIFT_STEP0;
      2'd1:    sh = SHIFT_STEP1;
      2'd2:    sh = SHIFT_STEP2;
      default: sh = SHIFT_STEP3;
    endcase
    return sh;
  endfunction

  function automatic logic [CORE_W-1:0] pick_nibble(input logic [OP_W-1:0] v,
                                                    input logic hi);
    return hi ? v[OP_W-1:CORE_W] : v[CORE_W-1:0];
  endfunction

endpackage

// File: rtl/c13_array_mult4x4.sv
// c13_array_mult4x4
//   Purely combinational 4x4 unsigned array multiplier. Partial products are
//   formed with AND gates, then each row is folded into the running sum by a
//   ripple chain of full adders (classic carry-propagate array).
//   Ports:
//     x  in  CORE_W    multiplicand nibble
//     y  in  CORE_W    multiplier nibble
//     p  out 2*CORE_W  x*y
module c13_array_mult4x4
  import c13_mult_pkg::*;
(
  input  logic [CORE_W-1:0]   x,
  input  logic [CORE_W-1:0]   y,
  output logic [2*CORE_W-1:0] p
);

  // pp_row[i][j] = x[j] & y[i]
  logic [CORE_W-1:0] pp_row [CORE_W];

  genvar gi;
  generate
    for (gi = 0; gi < CORE_W; gi++) begin : g_pp
      assign pp_row[gi] = x & {CORE_W{y[gi]}};
    end
  endgenerate

  // Row i is added to the running sum shifted down by one bit; the bit that
  // falls out the bottom is final product bit i.
  always_comb begin
    logic [CORE_W:0]   row_sum;
    logic [CORE_W-1:0] next_sum;
    logic              carry;
    logic              s_bit;
    logic              in_a;
    logic              in_b;

    p        = '0;
    row_sum  = {1'b0, pp_row[0]};
    next_sum = '0;
    carry    = 1'b0;
    s_bit    = 1'b0;
    in_a     = 1'b0;
    in_b     = 1'b0;
    p[0]     = row_sum[0];

    for (int i = 1; i < CORE_W; i++) begin
      carry = 1'b0;
      for (int j = 0; j < CORE_W; j++) begin
        in_a        = pp_row[i][j];
        in_b        = row_sum[j+1];
        s_bit       = in_a ^ in_b ^ carry;
        carry       = (in_a & in_b) | (carry & (in_a ^ in_b));
        next_sum[j] = s_bit;
      end
      row_sum = {carry, next_sum};
      p[i]    = row_sum[0];
    end

    p[2*CORE_W-1:CORE_W] = row_sum[CORE_W:1];
  end

endmodule

// File: rtl/c13_mult8_seq_ctrl.sv
// c13_mult8_seq_ctrl
//   8x8 unsigned multiplier that time-shares one 4x4 array core over four
//   cycles. Each step multiplies one nibble pair, shifts the 8-bit partial
//   product and adds it into a 16-bit accumulator.
//   Ports:
//     clk        in   1      clock, rising edge
//     rst        in   1      synchronous active-high reset
//     in_valid   in   1      operand pair presented
//     in_ready   out  1      high only in IDLE
//     a, b       in   8      unsigned operands
//     out_valid  out  1      product valid, held until out_ready
//     out_ready  in   1      consumer takes product
//     product    out  16     a*b (0 when not in DONE)
//     busy       out  1      high in MUL or DONE
//     op_count   out  CNT_W  delivered products since reset, wraps
module c13_mult8_seq_ctrl
  import c13_mult_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  state_t              state_reg, state_next;
  logic [STEP_W-1:0]   step_reg, step_next;
  logic [PROD_W-1:0]   acc_reg, acc_next;
  logic [OP_W-1:0]     a_q_reg, a_q_next;
  logic [OP_W-1:0]     b_q_reg, b_q_next;
  logic [CNT_W-1:0]    op_count_reg, op_count_next;

  logic [CORE_W-1:0]   a_nib;
  logic [CORE_W-1:0]   b_nib;
  logic [2*CORE_W-1:0] pp;
  logic [PROD_W-1:0]   pp_shifted;

  // step[0] selects the high nibble of a, step[1] the high nibble of b,
  // which walks lo*lo, hi*lo, lo*hi, hi*hi.
  assign a_nib = pick_nibble(a_q_reg, step_reg[0]);
  assign b_nib = pick_nibble(b_q_reg, step_reg[1]);

  c13_array_mult4x4 u_core (
    .x (a_nib),
    .y (b_nib),
    .p (pp)
  );

  // Zero-extend before shifting so the high-nibble products keep their bits.
  assign pp_shifted = PROD_W'(pp) << step_shift(step_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      step_reg     <= '0;
      acc_reg      <= '0;
      a_q_reg      <= '0;
      b_q_reg      <= '0;
      op_count_reg <= '0;
    end else begin
      state_reg    <= state_next;
      step_reg     <= step_next;
      acc_reg      <= acc_next;
      a_q_reg      <= a_q_next;
      b_q_reg      <= b_q_next;
      op_count_reg <= op_count_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    step_next     = step_reg;
    acc_next      = acc_reg;
    a_q_next      = a_q_reg;
    b_q_next      = b_q_reg;
    op_count_next = op_count_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          a_q_next   = a;
          b_q_next   = b;
          acc_next   = '0;
          step_next  = '0;
          state_next = MUL;
        end
      end
      MUL: begin
        acc_next  = acc_reg + pp_shifted;
        step_next = step_reg + 2'd1;
        if (step_reg == STEP_LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          op_count_next = op_count_reg + CNT_W'(1);
          state_next    = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg == MUL) || (state_reg == DONE);
  assign product   = (state_reg == DONE) ? acc_reg : '0;
  assign op_count  = op_count_reg;

endmodule

// File: tb/tb_c13_mult8_seq_ctrl.sv
module tb_c13_mult8_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;
  logic [7:0]  op_count;

  int errors = 0;
  int checks = 0;
  int exp_count = 0;   // reference: deliveries since last reset

  always #5 clk = ~clk;

  c13_mult8_seq_ctrl #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy),
    .op_count  (op_count)
  );

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full operation: wait for in_ready, handshake, expect the product
  // 4 cycles later, hold it for 'hold' cycles, then take it.
  task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input int hold,
                       input bit noise, input bit early_ready);
    int          cyc;
    int          ia;
    int          ib;
    logic [15:0] exp_p;
    logic [7:0]  exp_cnt;
    ia      = int'(av);
    ib      = int'(bv);
    exp_p   = 16'(ia * ib);
    cyc = 0;
    while (in_ready !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL in_ready_wait: got %b required 1", in_ready);
    end
    in_valid = 1'b1;
    a = av;
    b = bv;
    tick();
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL accept_state: in_ready=%b busy=%b required 0/1", in_ready, busy);
    end
    if (noise) begin
      in_valid = 1'b1;
      a = 8'h77;
      b = 8'h77;
    end else begin
      in_valid = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
    end
    out_ready = early_ready;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (cyc !== 4) begin
      errors++;
      $display("FAIL latency: got %0d cycles required 4 (a=%h b=%h)", cyc, av, bv);
    end
    checks++;
    if (product !== exp_p) begin
      errors++;
      $display("FAIL product: a=%h b=%h got %h required %h", av, bv, product, exp_p);
    end
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      a = 8'($urandom);
      tick();
      checks++;
      if (out_valid !== 1'b1 || product !== exp_p || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold: cycle %0d out_valid=%b product=%h in_ready=%b required 1/%h/0",
                 h, out_valid, product, in_ready, exp_p);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_count = (exp_count + 1) % 256;
    exp_cnt = 8'(exp_count);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || op_count !== exp_cnt) begin
      errors++;
      $display("FAIL take: out_valid=%b in_ready=%b op_count=%0d required 0/1/%0d",
               out_valid, in_ready, op_count, exp_cnt);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b1;   // must lose to reset
    out_ready = 1'b1;
    a = 8'hFF;
    b = 8'hFF;
    tick();
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    exp_count = 0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        product !== 16'h0000 || op_count !== 8'd0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b busy=%b product=%h op_count=%0d required 1/0/0/0000/0",
               in_ready, out_valid, busy, product, op_count);
    end
  endtask

  task automatic test_directed;
    do_op(8'hFF, 8'hFF, 0, 1'b0, 1'b1);
    checks++;
    if (op_count !== 8'd1) begin
      errors++;
      $display("FAIL first_count: got %0d required 1", op_count);
    end
    do_op(8'h00, 8'hA5, 0, 1'b0, 1'b0);
    do_op(8'h01, 8'h01, 1, 1'b0, 1'b0);
    do_op(8'h12, 8'h34, 10, 1'b0, 1'b0);
  endtask

  task automatic test_ignore_in_valid;
    do_op(8'h12, 8'h34, 2, 1'b1, 1'b0);
    do_op(8'h9C, 8'h3E, 0, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_op;
    do_op(8'h21, 8'h43, 0, 1'b0, 1'b0);
    in_valid = 1'b1;
    a = 8'hAB;
    b = 8'hCD;
    tick();          // accepted: step 0
    in_valid = 1'b0;
    tick();          // step 1
    tick();          // step 2
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    exp_count = 0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || op_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid: in_ready=%b out_valid=%b busy=%b op_count=%0d required 1/0/0/0",
               in_ready, out_valid, busy, op_count);
    end
    do_op(8'h5A, 8'hC3, 0, 1'b0, 1'b0);
  endtask

  task automatic test_corner_grid;
    logic [7:0] vals [7];
    vals[0] = 8'h00; vals[1] = 8'h01; vals[2] = 8'h0F; vals[3] = 8'h10;
    vals[4] = 8'hF0; vals[5] = 8'hFF; vals[6] = 8'h80;
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < 7; j++) begin
        do_op(vals[i], vals[j], 0, 1'b0, 1'b0);
      end
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 2500; n++) begin
      do_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_count_wrap;
    test_reset();
    for (int n = 0; n < 255; n++) begin
      do_op(8'($urandom), 8'($urandom), 0, 1'b0, 1'b1);
    end
    checks++;
    if (op_count !== 8'd255) begin
      errors++;
      $display("FAIL count_255: got %0d required 255", op_count);
    end
    do_op(8'hFF, 8'h02, 0, 1'b0, 1'b0);
    checks++;
    if (op_count !== 8'd0) begin
      errors++;
      $display("FAIL count_wrap: got %0d required 0", op_count);
    end
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = 8'h00;
    b = 8'h00;
    test_reset();
    test_directed();
    test_ignore_in_valid();
    test_reset_mid_op();
    test_corner_grid();
    test_random();
    test_count_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
